// File: rtl/cpu_mem_writeback.sv
// Memory/writeback pipeline stage: runs the data-bus handshake for loads and stores,
// stalls upstream while a transaction is outstanding, and issues one-cycle register writes.
module cpu_mem_writeback #(
  parameter int REGISTER_BITS = 4,
  parameter int BITS          = 16,
  parameter int ADDRESS_BITS  = 16
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic                     is_executing,
  input  logic [1:0]               mem_op,
  input  logic                     mem_byte,
  input  logic                     mem_sext,
  input  logic [BITS-1:0]          alu_result,
  input  logic [BITS-1:0]          store_data,
  input  logic [REGISTER_BITS-1:0] dest_reg,
  input  logic                     wb_en_in,
  output logic                     mem_valid,
  output logic                     mem_wr,
  output logic [ADDRESS_BITS-1:0]  mem_addr,
  output logic [BITS-1:0]          mem_wdata,
  output logic [BITS/8-1:0]        mem_be,
  input  logic                     mem_ready,
  input  logic [BITS-1:0]          mem_rdata,
  output logic                     reg_wr_en,
  output logic [REGISTER_BITS-1:0] reg_wr_addr,
  output logic [BITS-1:0]          reg_wr_data,
  output logic                     stall
);

  localparam int NB = BITS / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MEM = 1'b1} state_t;

  function automatic logic [NB-1:0] lane_be(input logic [LW-1:0] lane, input logic is_byte);
    logic [NB-1:0] be;
    be = {NB{1'b0}};
    if (!is_byte) begin
      be = {NB{1'b1}};
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (LW'(i) == lane) be[i] = 1'b1;
      end
    end
    return be;
  endfunction

  function automatic logic [BITS-1:0] load_extract(input logic [BITS-1:0] rdata,
                                                   input logic [LW-1:0]   lane,
                                                   input logic            is_byte,
                                                   input logic            sext);
    logic [7:0]      b;
    logic [BITS-1:0] res;
    b = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (LW'(i) == lane) b = rdata[i*8 +: 8];
    end
    if (!is_byte) begin
      res = rdata;
    end else if (sext) begin
      res = BITS'(signed'(b));
    end else begin
      res = BITS'(b);
    end
    return res;
  endfunction

  state_t                   state_q, state_d;
  logic                     mem_valid_q, mem_valid_d;
  logic                     mem_wr_q, mem_wr_d;
  logic [ADDRESS_BITS-1:0]  mem_addr_q, mem_addr_d;
  logic [BITS-1:0]          mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]            mem_be_q, mem_be_d;
  logic                     stall_q, stall_d;
  logic                     reg_wr_en_q, reg_wr_en_d;
  logic [REGISTER_BITS-1:0] reg_wr_addr_q, reg_wr_addr_d;
  logic [BITS-1:0]          reg_wr_data_q, reg_wr_data_d;
  logic [LW-1:0]            lane_q, lane_d;
  logic                     byte_q, byte_d;
  logic                     sext_q, sext_d;
  logic [REGISTER_BITS-1:0] dest_q, dest_d;

  logic [ADDRESS_BITS-1:0]  addr_s;
  logic [ADDRESS_BITS-1:0]  addr_aligned_s;
  logic [LW-1:0]            lane_s;

  // Address decode: lane select and word-aligned bus address
  always_comb begin
    addr_s         = ADDRESS_BITS'(alu_result);
    addr_aligned_s = addr_s;
    lane_s         = {LW{1'b0}};
    if (NB > 1) begin
      lane_s                      = addr_s[LW-1:0];
      addr_aligned_s[LW-1:0]      = {LW{1'b0}};
    end else begin
      lane_s = {LW{1'b0}};
    end
  end

  // Next-state and output computation
  always_comb begin
    state_d       = state_q;
    mem_valid_d   = mem_valid_q;
    mem_wr_d      = mem_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    stall_d       = stall_q;
    reg_wr_en_d   = 1'b0;
    reg_wr_addr_d = reg_wr_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    lane_d        = lane_q;
    byte_d        = byte_q;
    sext_d        = sext_q;
    dest_d        = dest_q;
    case (state_q)
      S_IDLE: begin
        if (is_executing && (mem_op == 2'b01 || mem_op == 2'b10)) begin
          state_d     = S_MEM;
          mem_valid_d = 1'b1;
          stall_d     = 1'b1;
          mem_wr_d    = (mem_op == 2'b10);
          mem_addr_d  = addr_aligned_s;
          mem_be_d    = lane_be(lane_s, mem_byte);
          mem_wdata_d = mem_byte ? {NB{store_data[7:0]}} : store_data;
          lane_d      = lane_s;
          byte_d      = mem_byte;
          sext_d      = mem_sext;
          dest_d      = dest_reg;
        end else if (is_executing && wb_en_in && (dest_reg != {REGISTER_BITS{1'b0}})) begin
          reg_wr_en_d   = 1'b1;
          reg_wr_addr_d = dest_reg;
          reg_wr_data_d = alu_result;
        end else begin
          reg_wr_en_d = 1'b0;
        end
      end
      S_MEM: begin
        // Inputs are ignored here; upstream is stalled and re-presents them.
        if (mem_ready) begin
          state_d     = S_IDLE;
          mem_valid_d = 1'b0;
          mem_wr_d    = 1'b0;
          stall_d     = 1'b0;
          if (!mem_wr_q && (dest_q != {REGISTER_BITS{1'b0}})) begin
            reg_wr_en_d   = 1'b1;
            reg_wr_addr_d = dest_q;
            reg_wr_data_d = load_extract(mem_rdata, lane_q, byte_q, sext_q);
          end else begin
            reg_wr_en_d = 1'b0;
          end
        end else begin
          state_d = S_MEM;
        end
      end
      default: begin
        state_d     = S_IDLE;
        mem_valid_d = 1'b0;
        mem_wr_d    = 1'b0;
        stall_d     = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RSTb) begin
    if (RSTb) begin
      state_q       <= S_IDLE;
      mem_valid_q   <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= {ADDRESS_BITS{1'b0}};
      mem_wdata_q   <= {BITS{1'b0}};
      mem_be_q      <= {NB{1'b0}};
      stall_q       <= 1'b0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_addr_q <= {REGISTER_BITS{1'b0}};
      reg_wr_data_q <= {BITS{1'b0}};
      lane_q        <= {LW{1'b0}};
      byte_q        <= 1'b0;
      sext_q        <= 1'b0;
      dest_q        <= {REGISTER_BITS{1'b0}};
    end else begin
      state_q       <= state_d;
      mem_valid_q   <= mem_valid_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      stall_q       <= stall_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      lane_q        <= lane_d;
      byte_q        <= byte_d;
      sext_q        <= sext_d;
      dest_q        <= dest_d;
    end
  end

  assign mem_valid   = mem_valid_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;
  assign stall       = stall_q;
  assign reg_wr_en   = reg_wr_en_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign reg_wr_data = reg_wr_data_q;

endmodule

// File: tb/tb_cpu_mem_writeback.sv
// Directed self-checking bench for cpu_mem_writeback: ALU writeback vector table
// plus hand-written load/store, wait-state and mid-transaction reset sequences.
module tb_cpu_mem_writeback;

  logic        CLK;
  logic        RSTb;
  logic        is_executing;
  logic [1:0]  mem_op;
  logic        mem_byte;
  logic        mem_sext;
  logic [15:0] alu_result;
  logic [15:0] store_data;
  logic [3:0]  dest_reg;
  logic        wb_en_in;
  logic        mem_valid;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        reg_wr_en;
  logic [3:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic        stall;

  int checks = 0;
  int errors = 0;

  cpu_mem_writeback dut (
    .CLK(CLK), .RSTb(RSTb), .is_executing(is_executing), .mem_op(mem_op),
    .mem_byte(mem_byte), .mem_sext(mem_sext), .alu_result(alu_result),
    .store_data(store_data), .dest_reg(dest_reg), .wb_en_in(wb_en_in),
    .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .stall(stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        exec;
    logic [1:0]  op;
    logic        wb;
    logic [3:0]  dest;
    logic [15:0] alu;
    logic        exp_en;
    logic [3:0]  exp_addr;
    logic [15:0] exp_data;
  } alu_vec_t;

  alu_vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic run_mem(input logic [1:0] op, input logic is_byte, input logic sext,
                         input logic [15:0] addr, input logic [15:0] sdata, input logic [3:0] dest,
                         input int waits, input logic [15:0] rdata,
                         input logic [15:0] exp_addr, input logic [1:0] exp_be,
                         input logic [15:0] exp_wdata, input logic exp_en, input logic [15:0] exp_data);
    is_executing = 1'b1; mem_op = op; mem_byte = is_byte; mem_sext = sext;
    alu_result = addr; store_data = sdata; dest_reg = dest; wb_en_in = 1'b0;
    mem_ready = 1'b0; mem_rdata = 16'hDEAD;
    step();
    // junk instruction during MEM must be ignored
    mem_op = 2'b00; wb_en_in = 1'b1; dest_reg = 4'd2; alu_result = 16'h7777;
    for (int c = 0; c <= waits; c++) begin
      chk("mem_valid_busy", {31'd0, mem_valid}, 32'd1);
      chk("stall_busy", {31'd0, stall}, 32'd1);
      chk("mem_wr", {31'd0, mem_wr}, {31'd0, (op == 2'b10)});
      chk("mem_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
      chk("mem_be", {30'd0, mem_be}, {30'd0, exp_be});
      if (op == 2'b10) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, exp_wdata});
      chk("no_wr_busy", {31'd0, reg_wr_en}, 32'd0);
      mem_ready = (c == waits);
      mem_rdata = (c == waits) ? rdata : 16'hDEAD;
      step();
    end
    is_executing = 1'b0; mem_ready = 1'b0; mem_rdata = 16'hDEAD;
    chk("mem_valid_done", {31'd0, mem_valid}, 32'd0);
    chk("stall_done", {31'd0, stall}, 32'd0);
    chk("mem_wr_done", {31'd0, mem_wr}, 32'd0);
    chk("load_wr_en", {31'd0, reg_wr_en}, {31'd0, exp_en});
    if (exp_en) begin
      chk("load_wr_addr", {28'd0, reg_wr_addr}, {28'd0, dest});
      chk("load_wr_data", {16'd0, reg_wr_data}, {16'd0, exp_data});
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'b00, 1'b1, 4'd3,  16'h1234, 1'b1, 4'd3,  16'h1234};
    vecs[1] = '{1'b1, 2'b00, 1'b1, 4'd0,  16'h5555, 1'b0, 4'd0,  16'h0000};
    vecs[2] = '{1'b0, 2'b00, 1'b1, 4'd5,  16'hAAAA, 1'b0, 4'd0,  16'h0000};
    vecs[3] = '{1'b1, 2'b11, 1'b1, 4'd7,  16'h0F0F, 1'b1, 4'd7,  16'h0F0F};
    vecs[4] = '{1'b1, 2'b00, 1'b0, 4'd9,  16'h1111, 1'b0, 4'd0,  16'h0000};
    vecs[5] = '{1'b1, 2'b00, 1'b1, 4'd15, 16'hFFFF, 1'b1, 4'd15, 16'hFFFF};
    vecs[6] = '{1'b1, 2'b00, 1'b1, 4'd1,  16'h0001, 1'b1, 4'd1,  16'h0001};

    // reset with random inputs
    RSTb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      is_executing = 1'($urandom); mem_op = 2'($urandom); mem_byte = 1'($urandom);
      mem_sext = 1'($urandom); alu_result = 16'($urandom); store_data = 16'($urandom);
      dest_reg = 4'($urandom); wb_en_in = 1'($urandom); mem_ready = 1'($urandom);
      mem_rdata = 16'($urandom);
      step();
    end
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_mem_be", {30'd0, mem_be}, 32'd0);
    chk("rst_reg_wr_en", {31'd0, reg_wr_en}, 32'd0);
    chk("rst_reg_wr_addr", {28'd0, reg_wr_addr}, 32'd0);
    chk("rst_reg_wr_data", {16'd0, reg_wr_data}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    RSTb = 1'b0;
    mem_byte = 1'b0; mem_sext = 1'b0; store_data = 16'h0000;

    // ALU writeback table; mem_ready held high to show it is ignored when idle
    for (int i = 0; i < 7; i++) begin
      is_executing = vecs[i].exec; mem_op = vecs[i].op; wb_en_in = vecs[i].wb;
      dest_reg = vecs[i].dest; alu_result = vecs[i].alu; mem_ready = 1'b1;
      step();
      chk("alu_wr_en", {31'd0, reg_wr_en}, {31'd0, vecs[i].exp_en});
      if (vecs[i].exp_en) begin
        chk("alu_wr_addr", {28'd0, reg_wr_addr}, {28'd0, vecs[i].exp_addr});
        chk("alu_wr_data", {16'd0, reg_wr_data}, {16'd0, vecs[i].exp_data});
      end
      chk("alu_no_valid", {31'd0, mem_valid}, 32'd0);
      chk("alu_no_stall", {31'd0, stall}, 32'd0);
    end
    is_executing = 1'b0;
    step();
    chk("alu_wr_one_cycle", {31'd0, reg_wr_en}, 32'd0);

    // word load, 3 wait cycles
    run_mem(2'b01, 1'b0, 1'b0, 16'h0040, 16'h0000, 4'd6, 3, 16'hBEEF,
            16'h0040, 2'b11, 16'h0000, 1'b1, 16'hBEEF);
    step();
    chk("load_wr_one_cycle", {31'd0, reg_wr_en}, 32'd0);

    // byte load, sign-extend, then ALU op captured on the writeback edge
    run_mem(2'b01, 1'b1, 1'b1, 16'h0041, 16'h0000, 4'd7, 0, 16'h80AA,
            16'h0040, 2'b10, 16'h0000, 1'b1, 16'hFF80);
    is_executing = 1'b1; mem_op = 2'b00; wb_en_in = 1'b1; dest_reg = 4'd9; alu_result = 16'h4242;
    step();
    is_executing = 1'b0;
    chk("b2b_wr_en", {31'd0, reg_wr_en}, 32'd1);
    chk("b2b_wr_addr", {28'd0, reg_wr_addr}, 32'd9);
    chk("b2b_wr_data", {16'd0, reg_wr_data}, 32'h4242);

    // byte load, zero-extend
    run_mem(2'b01, 1'b1, 1'b0, 16'h0041, 16'h0000, 4'd7, 0, 16'h80AA,
            16'h0040, 2'b10, 16'h0000, 1'b1, 16'h0080);
    // byte load lane 0, sign-extend
    run_mem(2'b01, 1'b1, 1'b1, 16'h0022, 16'h0000, 4'd4, 1, 16'h1290,
            16'h0022, 2'b01, 16'h0000, 1'b1, 16'hFF90);
    // byte store
    run_mem(2'b10, 1'b1, 1'b0, 16'h0010, 16'h0034, 4'd8, 1, 16'h5678,
            16'h0010, 2'b01, 16'h3434, 1'b0, 16'h0000);
    // word store
    run_mem(2'b10, 1'b0, 1'b0, 16'h0123, 16'hA5C3, 4'd8, 2, 16'h5678,
            16'h0122, 2'b11, 16'hA5C3, 1'b0, 16'h0000);
    // load to r0 is suppressed
    run_mem(2'b01, 1'b0, 1'b0, 16'h0060, 16'h0000, 4'd0, 0, 16'h9999,
            16'h0060, 2'b11, 16'h0000, 1'b0, 16'h0000);

    // reset asserted in the 2nd wait cycle of a load
    is_executing = 1'b1; mem_op = 2'b01; mem_byte = 1'b0; alu_result = 16'h0040;
    dest_reg = 4'd5; wb_en_in = 1'b0; mem_ready = 1'b0;
    step();
    is_executing = 1'b0;
    chk("rstmid_valid_pre", {31'd0, mem_valid}, 32'd1);
    step();
    #2 RSTb = 1'b1;
    #1;
    chk("rstmid_valid", {31'd0, mem_valid}, 32'd0);
    chk("rstmid_stall", {31'd0, stall}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    step();
    RSTb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstmid_no_wr", {31'd0, reg_wr_en}, 32'd0);
      chk("rstmid_no_valid", {31'd0, mem_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_mem_writeback.md
# cpu_mem_writeback

Pipeline stage directly downstream of `cpu_execute`. It takes the ALU result and any load/store request for the instruction in pipeline slot 3. It runs the data-memory bus handshake, which can take many cycles, and asserts `stall` to freeze upstream slots while a transaction is outstanding. It then issues a single-cycle register-file write of either the ALU result or the load data, which is byte-extracted and sign- or zero-extended.

## Interface
Parameters:
- REGISTER_BITS, 4, register index width (16 registers; r0 reads as zero)
- BITS, 16, datapath width; must be a multiple of 8
- ADDRESS_BITS, 16, data address width

Ports:
- CLK  in  1  clock, rising edge
- RSTb  in  1  asynchronous reset, active-high: asserted when 1; clears all state immediately
- is_executing  in  1  slot-3 instruction is valid this cycle
- mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- mem_byte  in  1  1 = byte access, 0 = full BITS word
- mem_sext  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend
- alu_result  in  BITS  ALU output; also the memory address (low ADDRESS_BITS bits) for load/store
- store_data  in  BITS  store value (regB)
- dest_reg  in  REGISTER_BITS  writeback register index
- wb_en_in  in  1  non-memory instruction writes `dest_reg`
- mem_valid  out  1  bus request
- mem_wr  out  1  1 = store
- mem_addr  out  ADDRESS_BITS  bus address (word-aligned: LSB forced 0 when BITS>8)
- mem_wdata  out  BITS  store data; byte stores replicate the byte to all lanes
- mem_be  out  BITS/8  byte-lane enables
- mem_ready  in  1  bus accepts/completes the current request
- mem_rdata  in  BITS  load data, valid when mem_ready=1 on a load
- reg_wr_en  out  1  register-file write strobe
- reg_wr_addr  out  REGISTER_BITS  write index
- reg_wr_data  out  BITS  write data
- stall  out  1  hold upstream stages

## Operation
- States: IDLE, MEM.
- In IDLE, on each rising edge with is_executing=1:
  - If mem_op=01 or 10, latch the address, data, byte lane, dest_reg, sext and op. Enter MEM with mem_valid=1 and stall=1.
  - Otherwise, if wb_en_in=1 and dest_reg≠0, register a write of alu_result: reg_wr_en=1 for exactly one cycle.
  - If is_executing=0, nothing is latched and reg_wr_en=0.
- In MEM, outputs are held stable until an edge samples mem_ready=1. On that edge:
  - mem_valid, mem_wr and stall clear, and the state returns to IDLE.
  - On a load with a latched dest_reg≠0, reg_wr_en=1 for one cycle with the extracted data.
  - Inputs presented during MEM are ignored; upstream is stalled and re-presents them.
- Byte lane selection:
  - Lane = address[log2(BITS/8)-1:0]; for BITS=16 this is address[0].
  - Lane 0 is bits [7:0] (little-endian).
  - mem_be has a one-hot bit at the lane; a word access sets all bits.
- Load extraction:
  - Byte loads take the selected lane, then sign-extend from bit 7 if sext=1, else zero-extend.
  - Word loads pass mem_rdata unchanged.
- Stores never write the register file. Writes to r0 are always suppressed.
- mem_op=11 is treated as a no-memory instruction and obeys wb_en_in.

## Timing
- Reset values: all outputs 0, state IDLE. RSTb asserted mid-MEM drops mem_valid and stall asynchronously; the transaction is abandoned with no writeback.
- ALU writeback latency: 1 cycle. The register write is visible on the edge after the instruction's capture edge.
- Memory transaction:
  - Capture edge E0: mem_valid=1 and stall=1 from E0.
  - If mem_ready is high at edge E0+1, that is the minimum access. mem_valid is high for exactly 1 cycle and the writeback appears after E0+1.
  - Load-to-register latency = 2 cycles + bus wait cycles.
- stall is registered; it is never combinational from mem_ready.
- mem_ready while mem_valid=0 is ignored.
- A new instruction can be captured on the same edge that reg_wr_en is issued for the previous instruction.
- Back-to-back loads: the second load is captured on the first edge after stall deasserts, so there is one idle bus cycle between them.

## Test plan
- Reset: hold RSTb=1 with random inputs → all outputs 0. Release it, present an ALU op with dest=3, alu_result=0x1234, wb_en=1 → next cycle reg_wr_en=1, addr=3, data=0x1234, for one cycle only.
- ALU write to r0 (wb_en=1, dest=0) → reg_wr_en stays 0.
- Word load from 0x0040 with 3 wait cycles, then mem_rdata=0xBEEF → mem_valid high for 4 cycles, stall high for 4 cycles, mem_be=11. Then a single reg_wr_en with data 0xBEEF.
- Byte load from 0x0041 with sext=1, rdata=0x80AA → mem_addr=0x0040, mem_be=10, reg_wr_data=0xFF80. Repeat with sext=0 → 0x0080.
- Byte store of 0x0034 to 0x0010 → mem_wr=1, mem_be=01, mem_wdata=0x3434, and no reg_wr_en.
- Assert RSTb in the 2nd wait cycle of a load, then return mem_ready=1 after reset → mem_valid and stall clear immediately, and reg_wr_en is never asserted.
